proc_param: RTL and testbench

- Parametrised successor to the lab multi-cycle processor.
- Has WIDTH-bit datapath, 8 general registers, an A/G accumulator pair and a 4-step control FSM.
- Adds logic ops (and, or, xor), a Zero status flag, a handled illegal opcode, a Run-gated IR load and a register read-back port for debug/verification.
- Sits between the instruction source (DIN/Run) and board I/O (RegOut).

---
 rtl/proc_param.sv | 207 ++++++++++++++++++++
 tb/tb_proc_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_param.sv
// -----------------------------------------------------------------------------
// proc_param -- parametrised multi-cycle processor.
//
// A WIDTH-bit datapath with eight general registers (r0..r7), an A/G
// accumulator pair and a four-step control FSM (T0..T3). Instructions arrive
// on DIN and are captured into IR in T0 when Run is high. Supported opcodes:
// mv, mvt, add, sub, and, or, xor; opcode 111 is illegal and completes as a
// no-op. The Zero flag tracks the result of the last ALU operation.
//
// Instruction word: III[W-1:W-3] M[W-4] X[W-5:W-7] D[DW-1:0], DW = WIDTH-7.
//   Operand B is rY = D[2:0] when M=0, otherwise D sign-extended to WIDTH.
//
// Ports:
//   Clock   in   1      rising-edge clock
//   Resetn  in   1      synchronous, active-low reset
//   Run     in   1      start request, sampled only in T0
//   DIN     in   WIDTH  instruction word
//   RegSel  in   3      selects the register shown on RegOut
//   RegOut  out  WIDTH  combinational copy of the selected register
//   Done    out  1      high in the final step of each instruction
//   Busy    out  1      high whenever the FSM is not in T0
//   Zero    out  1      registered; set when the last ALU result was zero
// -----------------------------------------------------------------------------
module proc_param #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    input  logic [2:0]       RegSel,
    output logic [WIDTH-1:0] RegOut,
    output logic             Done,
    output logic             Busy,
    output logic             Zero
);

    localparam int DW   = WIDTH - 7;
    localparam int HALF = WIDTH / 2;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [1:0] {BUS_REG, BUS_G, BUS_IMM, BUS_MVT} bus_sel_t;

    state_t   state, state_next;
    bus_sel_t bus_sel;

    logic [WIDTH-1:0]        ir;
    logic [WIDTH-1:0]        regs [8];
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] g;
    logic signed [WIDTH-1:0] bus;
    logic signed [WIDTH-1:0] alu_out;
    logic signed [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0]        mvt_val;
    logic [HALF-1:0]         mvt_low;

    logic [2:0]    opcode;
    logic          imm_mode;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [DW-1:0] d;
    logic [2:0]    bus_reg;

    logic ir_load, a_load, g_load, reg_we, done;

    // Instruction field decode
    assign opcode   = ir[WIDTH-1:WIDTH-3];
    assign imm_mode = ir[WIDTH-4];
    assign rx       = ir[WIDTH-5:WIDTH-7];
    assign d        = ir[DW-1:0];
    assign ry       = d[2:0];

    assign imm_ext = {{7{d[DW-1]}}, d};
    // For the narrowest builds HALF exceeds DW, so D is zero-extended first.
    assign mvt_low = HALF'(d);
    assign mvt_val = {mvt_low, {HALF{1'b0}}};

    // FSM state register
    always_ff @(posedge Clock) begin
        if (!Resetn)
            state <= T0;
        else
            state <= state_next;
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        done       = 1'b0;
        ir_load    = 1'b0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        reg_we     = 1'b0;
        bus_sel    = BUS_REG;
        bus_reg    = ry;

        case (state)
            T0: begin
                if (Run) begin
                    ir_load    = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel    = imm_mode ? BUS_IMM : BUS_REG;
                        reg_we     = 1'b1;
                        done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVT: begin
                        bus_sel    = BUS_MVT;
                        reg_we     = 1'b1;
                        done       = 1'b1;
                        state_next = T0;
                    end
                    OP_ILL: begin
                        done       = 1'b1;
                        state_next = T0;
                    end
                    default: begin
                        // ALU op: latch rX into A before the source is read,
                        // so rX == rY still yields the correct result.
                        bus_reg    = rx;
                        a_load     = 1'b1;
                        state_next = T2;
                    end
                endcase
            end
            T2: begin
                bus_sel    = imm_mode ? BUS_IMM : BUS_REG;
                g_load     = 1'b1;
                state_next = T3;
            end
            T3: begin
                bus_sel    = BUS_G;
                reg_we     = 1'b1;
                done       = 1'b1;
                state_next = T0;
            end
            default: state_next = T0;
        endcase
    end

    // Single internal bus
    always_comb begin
        bus = '0;
        case (bus_sel)
            BUS_REG: bus = regs[bus_reg];
            BUS_G:   bus = g;
            BUS_IMM: bus = imm_ext;
            BUS_MVT: bus = mvt_val;
            default: bus = '0;
        endcase
    end

    // ALU: two's-complement wraparound, carry/borrow discarded
    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = a + bus;
            OP_SUB:  alu_out = a - bus;
            OP_AND:  alu_out = a & bus;
            OP_OR:   alu_out = a | bus;
            OP_XOR:  alu_out = a ^ bus;
            default: alu_out = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            ir   <= '0;
            a    <= '0;
            g    <= '0;
            Zero <= 1'b0;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            if (ir_load)
                ir <= DIN;
            if (a_load)
                a <= bus;
            if (g_load) begin
                g    <= alu_out;
                Zero <= (alu_out == '0);
            end
            if (reg_we)
                regs[rx] <= bus;
        end
    end

    assign RegOut = regs[RegSel];
    assign Done   = done;
    assign Busy   = (state != T0);

endmodule

// File: tb/tb_proc_param.sv
module tb_proc_param;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic [2:0]  regsel;
    logic [15:0] regout;
    logic        done;
    logic        busy;
    logic        zero;

    logic        run24;
    logic [23:0] din24;
    logic [2:0]  regsel24;
    logic [23:0] regout24;
    logic        done24;
    logic        busy24;
    logic        zero24;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    logic        m_zero;
    logic [15:0] obs_regs [8];

    proc_param #(.WIDTH(16)) dut (
        .Clock (clock),
        .Resetn(resetn),
        .Run   (run),
        .DIN   (din),
        .RegSel(regsel),
        .RegOut(regout),
        .Done  (done),
        .Busy  (busy),
        .Zero  (zero)
    );

    proc_param #(.WIDTH(24)) dut24 (
        .Clock (clock),
        .Resetn(resetn),
        .Run   (run24),
        .DIN   (din24),
        .RegSel(regsel24),
        .RegOut(regout24),
        .Done  (done24),
        .Busy  (busy24),
        .Zero  (zero24)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_zero = 1'b0;
    endtask

    // Executes one instruction on the model; returns the cycle in which Done
    // is expected (cycle 1 = the T0 cycle that captures the word).
    function automatic int model_exec(input logic [15:0] instr);
        int          op, x, dv, sd;
        logic [15:0] b, av, r;
        op = int'(instr[15:13]);
        x  = int'(instr[11:9]);
        dv = int'(instr[8:0]);
        sd = (dv >= 256) ? dv - 512 : dv;
        b  = instr[12] ? 16'(sd) : m_regs[dv % 8];
        av = m_regs[x];
        case (op)
            0: begin m_regs[x] = b; return 2; end
            1: begin m_regs[x] = 16'((dv % 256) * 256); return 2; end
            7: return 2;
            default: begin
                case (op)
                    2: r = av + b;
                    3: r = av - b;
                    4: r = av & b;
                    5: r = av | b;
                    default: r = av ^ b;
                endcase
                m_regs[x] = r;
                m_zero = (r == 16'h0000);
                return 4;
            end
        endcase
    endfunction

    // ---------------- stimulus helpers (no comparisons) ----------------
    // Entered at #1 after an edge with the DUT in T0; returns #1 after the
    // edge following Done (DUT back in T0). Bit c of done_bits = Done in cycle c.
    task automatic run_instr(input logic [15:0] instr, output logic [8:0] done_bits);
        done_bits = '0;
        din = instr;
        run = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clock); #1;
            run = 1'b0;
            if (done === 1'b1) begin
                done_bits[c] = 1'b1;
                @(posedge clock); #1;
                break;
            end
        end
    endtask

    task automatic snap_regs();
        for (int i = 0; i < 8; i++) begin
            regsel = 3'(i);
            #1;
            obs_regs[i] = regout;
        end
    endtask

    function automatic logic [8:0] bit_at(input int c);
        logic [8:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0; run = 1'b0; din = '0; regsel = '0;
        run24 = 1'b0; din24 = '0; regsel24 = '0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
        snap_regs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_regs[i] !== 16'h0000) begin errors++; $display("FAIL reset_r%0d: got %h expected 0000", i, obs_regs[i]); end
        end
        resetn = 1'b1;
    endtask

    task automatic test_mv();
        logic [8:0] db;
        void'(model_exec(16'h1005));
        run_instr(16'h1005, db);
        checks++; if (db !== bit_at(2)) begin errors++; $display("FAIL mv_done_cycle: got %b expected %b", db, bit_at(2)); end
        snap_regs();
        checks++; if (obs_regs[0] !== 16'h0005) begin errors++; $display("FAIL mv_r0: got %h expected 0005", obs_regs[0]); end
        void'(model_exec(16'h13FF));
        run_instr(16'h13FF, db);
        snap_regs();
        checks++; if (obs_regs[1] !== 16'hFFFF) begin errors++; $display("FAIL mv_r1_sext: got %h expected ffff", obs_regs[1]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mv_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_mvt();
        logic [8:0] db;
        logic       zb;
        zb = m_zero;
        void'(model_exec(16'h34AB));
        run_instr(16'h34AB, db);
        checks++; if (db !== bit_at(2)) begin errors++; $display("FAIL mvt_done_cycle: got %b expected %b", db, bit_at(2)); end
        snap_regs();
        checks++; if (obs_regs[2] !== 16'hAB00) begin errors++; $display("FAIL mvt_r2: got %h expected ab00", obs_regs[2]); end
        checks++; if (zero !== zb) begin errors++; $display("FAIL mvt_zero: got %b expected %b", zero, zb); end
    endtask

    task automatic test_alu();
        logic [8:0] db;
        void'(model_exec(16'h5003));
        run_instr(16'h5003, db);
        checks++; if (db !== bit_at(4)) begin errors++; $display("FAIL add_done_cycle: got %b expected %b", db, bit_at(4)); end
        snap_regs();
        checks++; if (obs_regs[0] !== 16'h0008) begin errors++; $display("FAIL add_r0: got %h expected 0008", obs_regs[0]); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", zero); end
        void'(model_exec(16'h6000));
        run_instr(16'h6000, db);
        snap_regs();
        checks++; if (obs_regs[0] !== 16'h0000) begin errors++; $display("FAIL sub_self_r0: got %h expected 0000", obs_regs[0]); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_self_zero: got %b expected 1", zero); end
        void'(model_exec(16'h8401));
        run_instr(16'h8401, db);
        snap_regs();
        checks++; if (obs_regs[2] !== 16'hAB00) begin errors++; $display("FAIL and_r2: got %h expected ab00", obs_regs[2]); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL and_zero: got %b expected 0", zero); end
    endtask

    task automatic test_illegal();
        logic [8:0] db;
        void'(model_exec(16'h6603));   // sub r3,r3 sets Zero
        run_instr(16'h6603, db);
        void'(model_exec(16'hE000));
        run_instr(16'hE000, db);
        checks++; if (db !== bit_at(2)) begin errors++; $display("FAIL ill_done_cycle: got %b expected %b", db, bit_at(2)); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL ill_zero: got %b expected 1", zero); end
        snap_regs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_regs[i] !== m_regs[i]) begin errors++; $display("FAIL ill_r%0d: got %h expected %h", i, obs_regs[i], m_regs[i]); end
        end
        void'(model_exec(16'h1809));   // mv r4,#9 leaves Zero alone
        run_instr(16'h1809, db);
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL mv_keeps_zero: got %b expected 1", zero); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [4];
        for (int k = 0; k < 4; k++) begin
            prog[k] = 16'($urandom);
            prog[k][15:13] = 3'b000;
        end
        run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c % 2 == 1) begin
                din = prog[(c - 1) / 2];
                void'(model_exec(din));
            end
            @(posedge clock); #1;
            checks++;
            if (done !== (((c + 1) % 2) == 0)) begin
                errors++; $display("FAIL b2b_done_cycle%0d: got %b expected %b", c + 1, done, ((c + 1) % 2) == 0);
            end
        end
        run = 1'b0;
        @(posedge clock); #1;
        snap_regs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_regs[i] !== m_regs[i]) begin errors++; $display("FAIL b2b_r%0d: got %h expected %h", i, obs_regs[i], m_regs[i]); end
        end
    endtask

    task automatic test_run_while_busy();
        logic [8:0] db;
        void'(model_exec(16'h1A01));   // mv r5,#1
        run_instr(16'h1A01, db);
        din = 16'h5003;                // add r0,#3
        void'(model_exec(din));
        run = 1'b1;
        @(posedge clock); #1;          // T1
        run = 1'b0;
        din = 16'h1A07;                // mv r5,#7 offered while busy
        @(posedge clock); #1;          // T2
        run = 1'b1;
        @(posedge clock); #1;          // T3
        run = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_add_done: got %b expected 1", done); end
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_pulse_ignored: got busy %b expected 0", busy); end
        snap_regs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_regs[i] !== m_regs[i]) begin errors++; $display("FAIL busy_r%0d: got %h expected %h", i, obs_regs[i], m_regs[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] db;
        void'(model_exec(16'h6000));
        run_instr(16'h6000, db);       // Zero=1
        void'(model_exec(16'h1005));
        run_instr(16'h1005, db);       // r0=5
        din = 16'h5003;
        run = 1'b1;
        @(posedge clock); #1;          // T1
        run = 1'b0;
        @(posedge clock); #1;          // T2
        resetn = 1'b0;
        @(posedge clock); #1;
        model_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rstmid_zero: got %b expected 0", zero); end
        snap_regs();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_regs[i] !== 16'h0000) begin errors++; $display("FAIL rstmid_r%0d: got %h expected 0000", i, obs_regs[i]); end
        end
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        logic [8:0]  db;
        logic [15:0] instr;
        int          exp_c;
        for (int n = 0; n < 40; n++) begin
            instr = 16'($urandom);
            exp_c = model_exec(instr);
            run_instr(instr, db);
            checks++;
            if (db !== bit_at(exp_c)) begin errors++; $display("FAIL rand%0d_done %h: got %b expected %b", n, instr, db, bit_at(exp_c)); end
            checks++;
            if (zero !== m_zero) begin errors++; $display("FAIL rand%0d_zero %h: got %b expected %b", n, instr, zero, m_zero); end
            snap_regs();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_regs[i] !== m_regs[i]) begin errors++; $display("FAIL rand%0d_r%0d %h: got %h expected %h", n, i, instr, obs_regs[i], m_regs[i]); end
            end
        end
    endtask

    task automatic test_width24();
        din24 = 24'h17FFFE;            // mv r3,#-2
        run24 = 1'b1;
        @(posedge clock); #1;
        run24 = 1'b0;
        checks++; if (done24 !== 1'b1) begin errors++; $display("FAIL w24_mv_done: got %b expected 1", done24); end
        @(posedge clock); #1;
        regsel24 = 3'd3; #1;
        checks++; if (regout24 !== 24'hFFFFFE) begin errors++; $display("FAIL w24_mv_r3: got %h expected fffffe", regout24); end
        din24 = 24'h2600C5;            // mvt r3,#0x0C5
        run24 = 1'b1;
        @(posedge clock); #1;
        run24 = 1'b0;
        checks++; if (done24 !== 1'b1) begin errors++; $display("FAIL w24_mvt_done: got %b expected 1", done24); end
        @(posedge clock); #1;
        regsel24 = 3'd3; #1;
        checks++; if (regout24 !== 24'h0C5000) begin errors++; $display("FAIL w24_mvt_r3: got %h expected 0c5000", regout24); end
    endtask

    initial begin
        test_reset();
        test_width24();
        test_mv();
        test_mvt();
        test_alu();
        test_illegal();
        test_back_to_back();
        test_run_while_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
